dac_frame_scheduler: RTL and testbench

- Upstream companion of the DAC SPI serializer. Holds a 4-channel shadow of 16-bit DAC sample values.
- Formats each channel write into a 24-bit DAC command word and issues one-cycle send pulses to the serializer.
- Spaces send pulses by a fixed minimum gap because the serializer has no ready/busy output.
- After reset, sends a one-time init word (e.g. reference enable) before any sample traffic.

---
 rtl/dac_frame_scheduler.sv | 173 +++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
//   Keeps a 4-channel shadow of 16-bit DAC samples. It formats dirty channels
//   into 24-bit command words and hands them to the SPI serializer as one-cycle
//   send pulses. Pulses are spaced by at least GAP cycles because the
//   serializer has no ready/busy handshake. An optional init word goes out once
//   after reset, before any sample traffic.
// Ports
//   clock_in   system clock
//   reset      asynchronous, active-high reset
//   sample_in  sample value to write
//   sample_ch  target channel 0..3
//   sample_wr  one-cycle write strobe for sample_in/sample_ch
//   dac_data   command word to serializer, held stable between sends
//   dac_send   one-cycle send strobe to serializer
//   busy       high while the init word is pending or the gap counter runs
//   pending    per-channel dirty flags
//   overwrite  one-cycle pulse when a write hits an already-dirty channel
module dac_frame_scheduler #(
  parameter int unsigned GAP       = 560,
  parameter logic [3:0]  CMD_WRITE = 4'b0011,
  parameter logic [23:0] INIT_WORD = 24'h700000,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic [1:0]  sample_ch,
  input  logic        sample_wr,
  output logic [23:0] dac_data,
  output logic        dac_send,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        overwrite
);

  localparam int unsigned CH_N     = 4;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WORD_W   = 24;
  localparam int unsigned CNT_W    = $clog2(GAP);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = INIT_EN ? S_INIT : S_IDLE;

  state_t                          state_q, state_d;
  logic [WORD_W-1:0]               dac_data_q, dac_data_d;
  logic                            dac_send_q, dac_send_d;
  logic                            busy_q, busy_d;
  logic [CH_N-1:0]                 pending_q, pending_d;
  logic                            overwrite_q, overwrite_d;
  logic [CH_N-1:0][SAMPLE_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]                gap_cnt_q, gap_cnt_d;
  logic [CH_W-1:0]                 rr_ptr_q, rr_ptr_d;

  logic                            pick_found;
  logic [CH_W-1:0]                 pick_ch;
  logic [CH_W-1:0]                 search_idx;
  logic                            do_pick;
  logic [3:0]                      pick_addr;

  // Round-robin search: first dirty channel at or after rr_ptr, wrapping mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    search_idx = '0;
    for (int i = 0; i < CH_N; i++) begin
      search_idx = CH_W'(rr_ptr_q + CH_W'(i));
      if (!pick_found && pending_q[search_idx]) begin
        pick_found = 1'b1;
        pick_ch    = search_idx;
      end
    end
  end

  // One-hot channel address field of the command word.
  always_comb begin
    pick_addr = 4'(4'b0001 << pick_ch);
  end

  // Next-state, send sequencing and write path.
  always_comb begin
    state_d     = state_q;
    dac_data_d  = dac_data_q;
    dac_send_d  = 1'b0;
    gap_cnt_d   = gap_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    overwrite_d = 1'b0;
    do_pick     = 1'b0;

    case (state_q)
      S_INIT: begin
        dac_data_d = INIT_WORD;
        dac_send_d = 1'b1;
        gap_cnt_d  = CNT_W'(GAP - 1);
        state_d    = S_GAP;
      end
      S_IDLE: begin
        if (pick_found) begin
          do_pick              = 1'b1;
          dac_data_d           = {CMD_WRITE, pick_addr, shadow_q[pick_ch]};
          dac_send_d           = 1'b1;
          pending_d[pick_ch]   = 1'b0;
          rr_ptr_d             = CH_W'(pick_ch + CH_W'(1));
          gap_cnt_d            = CNT_W'(GAP - 1);
          state_d              = S_GAP;
        end
      end
      S_GAP: begin
        // Leaving on the edge that reaches zero keeps sends exactly GAP apart.
        if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
        end
        if (gap_cnt_q != '0) begin
          gap_cnt_d = CNT_W'(gap_cnt_q - CNT_W'(1));
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write that lands on the channel being picked re-arms its dirty flag;
    // the word just sent carries the old value, so this is not an overwrite.
    if (sample_wr) begin
      shadow_d[sample_ch] = sample_in;
      if (pending_q[sample_ch] && !(do_pick && (pick_ch == sample_ch))) begin
        overwrite_d = 1'b1;
      end
      pending_d[sample_ch] = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      dac_data_q  <= '0;
      dac_send_q  <= 1'b0;
      busy_q      <= INIT_EN;
      pending_q   <= '0;
      overwrite_q <= 1'b0;
      shadow_q    <= '0;
      gap_cnt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      dac_data_q  <= dac_data_d;
      dac_send_q  <= dac_send_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      overwrite_q <= overwrite_d;
      shadow_q    <= shadow_d;
      gap_cnt_q   <= gap_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign dac_data  = dac_data_q;
  assign dac_send  = dac_send_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overwrite = overwrite_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Testbench for dac_frame_scheduler: scoreboard of expected command words,
// send spacing, busy window, overwrite and reset behaviour.
module tb_dac_frame_scheduler;

  localparam int unsigned GAP = 560;

  logic        clock_in;
  logic        reset;
  logic [15:0] sample_in;
  logic [1:0]  sample_ch;
  logic        sample_wr;
  logic [23:0] dac_data;
  logic        dac_send;
  logic        busy;
  logic [3:0]  pending;
  logic        overwrite;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_send = 0;
  logic [23:0] exp_q[$];

  dac_frame_scheduler #(
    .GAP(GAP),
    .CMD_WRITE(4'b0011),
    .INIT_WORD(24'h700000),
    .INIT_EN(1'b1)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .sample_in(sample_in),
    .sample_ch(sample_ch),
    .sample_wr(sample_wr),
    .dac_data (dac_data),
    .dac_send (dac_send),
    .busy     (busy),
    .pending  (pending),
    .overwrite(overwrite)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
    cyc++;
  endtask

  // One-cycle write strobe; returns sampled just after the write edge.
  task automatic drive(input logic [1:0] ch, input logic [15:0] val);
    sample_wr = 1'b1;
    sample_ch = ch;
    sample_in = val;
    tick();
    sample_wr = 1'b0;
  endtask

  task automatic wait_send(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (dac_send === 1'b1) seen = 1'b1;
    end
  endtask

  function automatic logic [23:0] pop_exp();
    if (exp_q.size() == 0) return 24'hxxxxxx;
    return exp_q.pop_front();
  endfunction

  // Walks the GAP-1 cycles after a send; busy must stay high until the last.
  task automatic gap_tail(output int extra, output int early_low, output logic busy_end);
    extra = 0;
    early_low = 0;
    for (int k = 1; k < GAP; k++) begin
      tick();
      if (dac_send !== 1'b0) extra++;
      if (k < GAP - 1 && busy !== 1'b1) early_low++;
    end
    busy_end = busy;
  endtask

  task automatic test_reset();
    int extra, early;
    logic b_end;
    logic [23:0] e;
    reset = 1'b1;
    sample_wr = 1'b0;
    sample_ch = '0;
    sample_in = '0;
    #3;
    checks++;
    if ({dac_send, dac_data, pending, overwrite} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: send=%b data=%h pend=%b ovw=%b, want all 0",
               dac_send, dac_data, pending, overwrite);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    tick();
    tick();
    reset = 1'b0;
    exp_q.push_back(24'h700000);
    tick();
    checks++;
    if (dac_send !== 1'b1) begin errors++; $display("FAIL init_send: got %b want 1", dac_send); end
    e = pop_exp();
    checks++;
    if (dac_data !== e) begin errors++; $display("FAIL init_word: got %h want %h", dac_data, e); end
    last_send = cyc;
    gap_tail(extra, early, b_end);
    checks++;
    if (extra != 0) begin errors++; $display("FAIL init_gap_sends: got %0d want 0", extra); end
    checks++;
    if (early != 0) begin errors++; $display("FAIL init_gap_busy: low %0d cycles early", early); end
    checks++;
    if (b_end !== 1'b0) begin errors++; $display("FAIL init_gap_end_busy: got %b want 0", b_end); end
    tick();
    checks++;
    if ({dac_send, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_quiet: send=%b busy=%b want 0 0", dac_send, busy);
    end
  endtask

  task automatic test_single_write();
    int extra, early;
    logic b_end;
    logic [23:0] e;
    exp_q.push_back(24'h341234);
    drive(2'd2, 16'h1234);
    checks++;
    if ({dac_send, pending} !== 5'b0_0100) begin
      errors++;
      $display("FAIL single_after_write: send=%b pend=%b want 0 0100", dac_send, pending);
    end
    tick();
    checks++;
    if (dac_send !== 1'b1) begin errors++; $display("FAIL single_send: got %b want 1", dac_send); end
    e = pop_exp();
    checks++;
    if (dac_data !== e) begin errors++; $display("FAIL single_word: got %h want %h", dac_data, e); end
    checks++;
    if ({pending, busy} !== 5'b0000_1) begin
      errors++;
      $display("FAIL single_pend_busy: pend=%b busy=%b want 0000 1", pending, busy);
    end
    last_send = cyc;
    gap_tail(extra, early, b_end);
    checks++;
    if (extra != 0 || early != 0 || b_end !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: extra=%0d early_low=%0d busy_end=%b want 0 0 0", extra, early, b_end);
    end
  endtask

  task automatic test_round_robin();
    int extra, early;
    logic b_end;
    bit seen;
    logic [23:0] e;
    exp_q.push_back(24'h31AAAA);
    exp_q.push_back(24'h320F0F);
    exp_q.push_back(24'h385555);
    drive(2'd0, 16'hAAAA);
    drive(2'd3, 16'h5555);
    checks++;
    if (dac_send !== 1'b1) begin errors++; $display("FAIL rr_first_send: got %b want 1", dac_send); end
    e = pop_exp();
    checks++;
    if (dac_data !== e) begin errors++; $display("FAIL rr_word0: got %h want %h", dac_data, e); end
    last_send = cyc;
    drive(2'd1, 16'h0F0F);
    checks++;
    if (pending !== 4'b1010) begin errors++; $display("FAIL rr_pending: got %b want 1010", pending); end
    for (int w = 1; w < 3; w++) begin
      wait_send(GAP + 40, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL rr_timeout%0d: got no send want send", w); end
      e = pop_exp();
      checks++;
      if (dac_data !== e) begin errors++; $display("FAIL rr_word%0d: got %h want %h", w, dac_data, e); end
      checks++;
      if (cyc - last_send != GAP) begin
        errors++;
        $display("FAIL rr_spacing%0d: got %0d want %0d", w, cyc - last_send, GAP);
      end
      last_send = cyc;
    end
    gap_tail(extra, early, b_end);
    checks++;
    if (extra != 0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL rr_tail: extra=%0d pend=%b want 0 0000", extra, pending);
    end
  endtask

  task automatic test_overwrite();
    int extra, early;
    logic b_end;
    bit seen;
    logic [23:0] e;
    exp_q.push_back(24'h310042);
    drive(2'd0, 16'h0042);
    tick();
    e = pop_exp();
    checks++;
    if (dac_send !== 1'b1 || dac_data !== e) begin
      errors++;
      $display("FAIL ovw_setup: send=%b data=%h want 1 %h", dac_send, dac_data, e);
    end
    last_send = cyc;
    drive(2'd1, 16'h1111);
    checks++;
    if (overwrite !== 1'b0) begin errors++; $display("FAIL ovw_first: got %b want 0", overwrite); end
    drive(2'd1, 16'h2222);
    checks++;
    if (overwrite !== 1'b1) begin errors++; $display("FAIL ovw_second: got %b want 1", overwrite); end
    tick();
    checks++;
    if (overwrite !== 1'b0) begin errors++; $display("FAIL ovw_pulse_len: got %b want 0", overwrite); end
    exp_q.push_back(24'h322222);
    wait_send(GAP + 40, seen);
    e = pop_exp();
    checks++;
    if (!seen || dac_data !== e) begin
      errors++;
      $display("FAIL ovw_word: seen=%b data=%h want 1 %h", seen, dac_data, e);
    end
    checks++;
    if (cyc - last_send != GAP) begin
      errors++;
      $display("FAIL ovw_spacing: got %0d want %0d", cyc - last_send, GAP);
    end
    last_send = cyc;
    gap_tail(extra, early, b_end);
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ovw_extra_sends: got %0d want 0", extra); end
  endtask

  task automatic test_same_edge();
    int extra, early;
    logic b_end;
    bit seen;
    logic [23:0] e;
    exp_q.push_back(24'h310001);
    exp_q.push_back(24'h31BEEF);
    drive(2'd0, 16'h0001);
    drive(2'd0, 16'hBEEF);
    e = pop_exp();
    checks++;
    if (dac_send !== 1'b1 || dac_data !== e) begin
      errors++;
      $display("FAIL same_edge_word: send=%b data=%h want 1 %h", dac_send, dac_data, e);
    end
    checks++;
    if (pending[0] !== 1'b1 || overwrite !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_flags: pend0=%b ovw=%b want 1 0", pending[0], overwrite);
    end
    last_send = cyc;
    wait_send(GAP + 40, seen);
    e = pop_exp();
    checks++;
    if (!seen || dac_data !== e || pending !== 4'b0000) begin
      errors++;
      $display("FAIL same_edge_resend: seen=%b data=%h pend=%b want 1 %h 0000", seen, dac_data, pending, e);
    end
    checks++;
    if (cyc - last_send != GAP) begin
      errors++;
      $display("FAIL same_edge_spacing: got %0d want %0d", cyc - last_send, GAP);
    end
    last_send = cyc;
    gap_tail(extra, early, b_end);
  endtask

  task automatic test_reset_mid_gap();
    logic [23:0] e;
    exp_q.push_back(24'h310007);
    drive(2'd0, 16'h0007);
    drive(2'd1, 16'h0101);
    e = pop_exp();
    checks++;
    if (dac_send !== 1'b1 || dac_data !== e) begin
      errors++;
      $display("FAIL midreset_setup: send=%b data=%h want 1 %h", dac_send, dac_data, e);
    end
    last_send = cyc;
    drive(2'd2, 16'h0202);
    drive(2'd3, 16'h0303);
    checks++;
    if (pending !== 4'b1110) begin errors++; $display("FAIL midreset_pending: got %b want 1110", pending); end
    while (cyc - last_send < 100) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({dac_send, dac_data, pending, overwrite} !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: send=%b data=%h pend=%b ovw=%b busy=%b want 0 0 0 0 1",
               dac_send, dac_data, pending, overwrite, busy);
    end
    // Pending words are abandoned by the reset.
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    exp_q.push_back(24'h700000);
    tick();
    e = pop_exp();
    checks++;
    if (dac_send !== 1'b1 || dac_data !== e || pending !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_init: send=%b data=%h pend=%b want 1 %h 0000", dac_send, dac_data, pending, e);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_overwrite();
    test_same_edge();
    test_reset_mid_gap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
